// File: rtl/gated_bus_driver.sv
// Transmit side of the 8-bit gated byte bus: byte FIFO feeding a qualifier FSM.
// Optional receiver handshake (WAIT_ACK, timeout, Error) enabled by GATED_BUS_ACK_EN.
module gated_bus_driver #(
    parameter int DEPTH       = 4,
    parameter int HOLD        = 1,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                     Clock,
    input  logic                     Reset_n,
    input  logic [7:0]               InData,
    input  logic                     InValid,
    output logic                     InReady,
    output logic [7:0]               BusData,
    output logic [2:0]               BusSel,
    input  logic                     BusAck,
    output logic                     Busy,
    output logic [$clog2(DEPTH):0]   Count,
    output logic                     Error
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [3:0] HOLD_L = 4'(HOLD);

    typedef enum logic [1:0] {IDLE, DRIVE, WAIT_ACK, GAP} state_t;

    state_t          state_q, state_d;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wptr, rptr;
    logic [CW-1:0]   count_d;
    logic [3:0]      hold_q, hold_d;
    logic [7:0]      byte_q;
    logic            push, pop, qual;

    assign push = InValid && InReady;
    assign pop  = (state_q == IDLE) && (Count != '0);
    assign qual = (state_q == DRIVE) || (state_q == WAIT_ACK);

`ifdef GATED_BUS_ACK_EN
    localparam logic [7:0] TMO_L = 8'(ACK_TIMEOUT - 1);
    logic [7:0] tmo_q, tmo_d;
    logic       err_d;
`else
    logic unused_ack;
    assign unused_ack = BusAck;
    assign Error      = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
`ifdef GATED_BUS_ACK_EN
        tmo_d   = tmo_q;
        err_d   = 1'b0;
`endif
        case ({push, pop})
            2'b10:   count_d = Count + 1'b1;
            2'b01:   count_d = Count - 1'b1;
            default: count_d = Count;
        endcase
        case (state_q)
            IDLE: begin
                if (pop) begin
                    state_d = DRIVE;
                    hold_d  = HOLD_L;
                end
            end
            DRIVE: begin
                hold_d = hold_q - 4'd1;
                if (hold_q == 4'd1) begin
`ifdef GATED_BUS_ACK_EN
                    state_d = WAIT_ACK;
                    tmo_d   = '0;
`else
                    state_d = GAP;
`endif
                end
            end
`ifdef GATED_BUS_ACK_EN
            WAIT_ACK: begin
                if (BusAck) begin
                    state_d = GAP;
                end else if (tmo_q == TMO_L) begin
                    // byte is abandoned on timeout, no retry
                    state_d = GAP;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
`endif
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (push) mem[wptr] <= InData;
    end

    // Bus outputs follow the state one cycle late, giving push-to-qualify latency of two edges.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            wptr    <= '0;
            rptr    <= '0;
            Count   <= '0;
            InReady <= 1'b1;
            hold_q  <= '0;
            byte_q  <= '0;
            BusData <= '0;
            BusSel  <= '0;
            Busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            Count   <= count_d;
            InReady <= (count_d != CW'(DEPTH));
            Busy    <= (count_d != '0) || (state_d != IDLE);
            if (push) wptr <= wptr + 1'b1;
            if (pop) begin
                rptr   <= rptr + 1'b1;
                byte_q <= mem[rptr];
            end
            BusSel  <= qual ? '1 : '0;
            BusData <= qual ? byte_q : '0;
        end
    end

`ifdef GATED_BUS_ACK_EN
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            tmo_q <= '0;
            Error <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            Error <= err_d;
        end
    end
`endif

endmodule

// File: tb/tb_gated_bus_driver.sv
// Scoreboard bench for gated_bus_driver: HOLD=1 and HOLD=3 instances, DEPTH=4.
// Handshake scenarios are compiled in with GATED_BUS_ACK_EN.
module tb_gated_bus_driver;

    localparam int HOLD1 = 1;
    localparam int HOLD3 = 3;
`ifdef GATED_BUS_ACK_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif
    localparam int P1 = HOLD1 + 2 + EXTRA;

    typedef struct {
        logic [7:0] d;
        int         len;
    } exp_t;

    logic       clk, rst_n;
    logic [7:0] in1_data, in3_data, bdata1, bdata3;
    logic       in1_valid, in3_valid, ready1, ready3, ack1, ack3;
    logic [2:0] bsel1, bsel3, count1, count3;
    logic       busy1, busy3, err1, err3;

    int   checks = 0;
    int   failures = 0;
    exp_t q1[$];
    exp_t q3[$];
    exp_t e1, e3;
    int   run1 = 0, run3 = 0;
    int   exp_cnt [5] = '{1, 1, 2, 3, 4};

    gated_bus_driver #(.DEPTH(4), .HOLD(HOLD1), .ACK_TIMEOUT(4)) dut1 (
        .Clock(clk), .Reset_n(rst_n), .InData(in1_data), .InValid(in1_valid),
        .InReady(ready1), .BusData(bdata1), .BusSel(bsel1), .BusAck(ack1),
        .Busy(busy1), .Count(count1), .Error(err1));

    gated_bus_driver #(.DEPTH(4), .HOLD(HOLD3), .ACK_TIMEOUT(4)) dut3 (
        .Clock(clk), .Reset_n(rst_n), .InData(in3_data), .InValid(in3_valid),
        .InReady(ready3), .BusData(bdata3), .BusSel(bsel3), .BusAck(ack3),
        .Busy(busy3), .Count(count3), .Error(err3));

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            run1 = 0;
        end else if (bsel1 == 3'b111) begin
            if (run1 == 0) begin
                if (q1.size() == 0) chk("d1_unexpected_byte", bdata1, -1);
                else begin
                    e1 = q1.pop_front();
                    chk("d1_bus_data", bdata1, e1.d);
                end
            end else chk("d1_data_stable", bdata1, e1.d);
            run1++;
        end else begin
            if (bsel1 != 3'b000) chk("d1_sel_code", bsel1, 0);
            if (bdata1 != 8'h00) chk("d1_gated_data", bdata1, 0);
            if (run1 > 0) chk("d1_qual_len", run1, e1.len);
            run1 = 0;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            run3 = 0;
        end else if (bsel3 == 3'b111) begin
            if (run3 == 0) begin
                if (q3.size() == 0) chk("d3_unexpected_byte", bdata3, -1);
                else begin
                    e3 = q3.pop_front();
                    chk("d3_bus_data", bdata3, e3.d);
                end
            end else chk("d3_data_stable", bdata3, e3.d);
            run3++;
        end else begin
            if (bsel3 != 3'b000) chk("d3_sel_code", bsel3, 0);
            if (bdata3 != 8'h00) chk("d3_gated_data", bdata3, 0);
            if (run3 > 0) chk("d3_qual_len", run3, e3.len);
            run3 = 0;
        end
    end

    task automatic wait_idle1();
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!busy1 && bsel1 == 3'b000 && q1.size() == 0) break;
        end
        chk("d1_drain", int'(k < 200), 1);
    endtask

    task automatic wait_idle3();
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!busy3 && bsel3 == 3'b000 && q3.size() == 0) break;
        end
        chk("d3_drain", int'(k < 200), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  k;
        bit  r;
        bit  v;
        logic [7:0] nxt;
        clk = 0; rst_n = 0;
        in1_data = '0; in1_valid = 0; in3_data = '0; in3_valid = 0;
        ack1 = 1; ack3 = 1;
        repeat (2) @(negedge clk);
        chk("rst_ready", ready1, 1);
        chk("rst_sel", bsel1, 0);
        chk("rst_data", bdata1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_count", count1, 0);
        chk("rst_error", err1, 0);
        rst_n = 1;
        @(negedge clk);

        // single byte, HOLD=1
        in1_data = 8'hA5; in1_valid = 1;
        q1.push_back('{8'hA5, HOLD1 + EXTRA});
        @(negedge clk);
        in1_valid = 0;
        chk("t1_count_push", count1, 1);
        chk("t1_busy", busy1, 1);
        chk("t1_sel_edge_n", bsel1, 0);
        @(negedge clk);
        chk("t1_count_pop", count1, 0);
        chk("t1_sel_edge_n1", bsel1, 0);
        for (int j = 0; j < HOLD1 + EXTRA; j++) begin
            @(negedge clk);
            chk("t1_qualified", bsel1, 3'b111);
            chk("t1_data", bdata1, 8'hA5);
        end
        @(negedge clk);
        chk("t1_gap_sel", bsel1, 0);
        chk("t1_gap_data", bdata1, 0);
        chk("t1_busy_end", busy1, 0);
        chk("t1_error", err1, 0);

        // back-to-back fill with HOLD=3, then a push that has to stall
        for (int i = 0; i < 5; i++) begin
            in3_data = 8'(i + 1); in3_valid = 1;
            q3.push_back('{8'(i + 1), HOLD3 + EXTRA});
            @(negedge clk);
            chk("t2_count", count3, exp_cnt[i]);
        end
        chk("t2_ready_full", ready3, 0);
        in3_data = 8'h06;
        q3.push_back('{8'h06, HOLD3 + EXTRA});
        r = 0;
        for (k = 0; k < 30; k++) begin
            r = ready3;
            @(negedge clk);
            if (r) break;
        end
        in3_valid = 0;
        chk("t2_stall_cycles", k, 2 + EXTRA);
        chk("t2_count_after_stall", count3, 4);
        wait_idle3();

        // steady Count=2: push only on pop edges, pointers wrap
        nxt = 8'h10;
        for (int e = 0; e <= 2 + 8 * P1; e++) begin
            v = (e <= 2) || ((e - 1) % P1 == 0);
            in1_valid = v;
            if (v) begin
                in1_data = nxt;
                q1.push_back('{nxt, HOLD1 + EXTRA});
                nxt++;
            end
            @(negedge clk);
            if (e >= 2) chk("t3_count_steady", count1, 2);
        end
        in1_valid = 0;
        wait_idle1();

`ifdef GATED_BUS_ACK_EN
        // acknowledge on the third WAIT_ACK cycle
        ack1 = 0;
        in1_data = 8'h5A; in1_valid = 1;
        q1.push_back('{8'h5A, HOLD1 + 3});
        @(negedge clk);
        in1_valid = 0;
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            chk("ack_no_error", err1, 0);
            if (j == HOLD1 + 3) ack1 = 1;
            if (j == HOLD1 + 4) ack1 = 0;
        end
        wait_idle1();
        // timeout: Error pulse, byte dropped, next byte proceeds
        in1_data = 8'hC3; in1_valid = 1;
        q1.push_back('{8'hC3, HOLD1 + 4});
        @(negedge clk);
        in1_valid = 0;
        for (int j = 1; j <= 9; j++) begin
            @(negedge clk);
            chk("tmo_error_pulse", err1, int'(j == HOLD1 + 5));
        end
        ack1 = 1;
        in1_data = 8'h77; in1_valid = 1;
        q1.push_back('{8'h77, HOLD1 + 1});
        @(negedge clk);
        in1_valid = 0;
        wait_idle1();
`endif

        // asynchronous reset in the middle of DRIVE
        for (int i = 0; i < 3; i++) begin
            in1_data = 8'(8'h31 + i); in1_valid = 1;
            q1.push_back('{8'(8'h31 + i), HOLD1 + EXTRA});
            @(negedge clk);
        end
        in1_valid = 0;
        for (k = 0; k < 20; k++) begin
            if (bsel1 == 3'b111) break;
            @(negedge clk);
        end
        chk("mid_reach_drive", int'(k < 20), 1);
        #2 rst_n = 0;
        #1;
        chk("mid_rst_sel", bsel1, 0);
        chk("mid_rst_data", bdata1, 0);
        chk("mid_rst_count", count1, 0);
        chk("mid_rst_ready", ready1, 1);
        q1.delete();
        @(negedge clk);
        #2 rst_n = 1;
        @(negedge clk);
        in1_data = 8'h3C; in1_valid = 1;
        q1.push_back('{8'h3C, HOLD1 + EXTRA});
        @(negedge clk);
        in1_valid = 0;
        chk("resume_count", count1, 1);
        wait_idle1();
        wait_idle3();

        chk("q1_empty", q1.size(), 0);
        chk("q3_empty", q3.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gated_bus_driver.md
# gated_bus_driver

Transmit side of the 8-bit gated byte bus. It queues bytes from an upstream producer and places each one on the bus with the 3-bit qualifier driven to 3'b111. Receivers AND every data bit with all three qualifier bits, so the bus reads 8'h00 whenever any qualifier bit is low. The block sits between a register or controller stage and any number of receivers that share the gated bus.

## Interface
- DEPTH, 4: FIFO entries; a power of two, 2 to 16.
- HOLD, 1: cycles a byte is qualified on the bus; 1 to 15.
- ACK_TIMEOUT, 15: cycles to wait for BusAck (ACK build only); 1 to 255.
- Clock  input  1  single clock; rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- InData  input  8  byte from producer.
- InValid  input  1  InData is valid.
- InReady  output  1  FIFO can accept; equals !full, registered.
- BusData  output  8  byte driven onto gated bus.
- BusSel  output  3  qualifier: 3'b111 qualifies the byte, 3'b000 otherwise; no other codes.
- BusAck  input  1  receiver acknowledge (ACK build only).
- Busy  output  1  FIFO non-empty or FSM not IDLE.
- Count  output  $clog2(DEPTH)+1  FIFO occupancy.
- Error  output  1  one-cycle pulse on ACK timeout (ACK build only; tied 0 otherwise).

## Operation
- Push: InValid && InReady at a rising edge writes InData at the write pointer. Pointers wrap modulo DEPTH.
- A push while full is impossible because InReady=0. The producer holds InValid and InData until the push is accepted.
- FSM states: IDLE, DRIVE, WAIT_ACK (ACK build only), GAP.
- IDLE -> DRIVE when the FIFO is non-empty: pop the head into the output register and load the hold counter with HOLD.
- In DRIVE: BusSel=3'b111 and BusData=the popped byte. The counter decrements each cycle. At 0 the FSM goes to WAIT_ACK in the ACK build, otherwise to GAP.
- In WAIT_ACK: BusSel stays 3'b111 and BusData stays the byte.
  - BusAck=1 -> GAP.
  - ACK_TIMEOUT cycles with no BusAck -> pulse Error and go to GAP. The byte is dropped, with no retry.
- In GAP: BusSel=3'b000 and BusData=8'h00 for exactly one cycle, then go to IDLE. This guarantees a de-qualified cycle between consecutive bytes.
- Outside DRIVE and WAIT_ACK, BusData=8'h00 and BusSel=3'b000.
- Push and pop in the same cycle: Count is unchanged and both pointers advance.
- Count is updated on the same edge as the push or pop. InReady is recomputed from the next Count.

## Timing
- Reset, asynchronous, any state: FSM=IDLE, pointers=0, Count=0, InReady=1, BusData=8'h00, BusSel=3'b000, Busy=0, Error=0.
  - FIFO contents need no reset.
  - Reset mid-byte removes the qualifier immediately, without waiting for a clock.
- All outputs are registered.
- Latency: a byte pushed into an empty, idle block at edge N is popped at edge N+1 and qualified from edge N+2.
- Each byte occupies the bus for HOLD + 1 cycles, including GAP. In the ACK build, add the WAIT_ACK cycles.
- Back-to-back throughput with no ACK: one byte per HOLD+2 cycles, including the IDLE cycle.
- In the ACK build, BusAck is sampled only in WAIT_ACK; a BusAck in any other state is ignored.

## Configuration
- GATED_BUS_ACK_EN defined: the WAIT_ACK state, BusAck, the timeout counter and the Error pulse are compiled in.
- GATED_BUS_ACK_EN undefined:
  - the BusAck port still exists but is ignored;
  - Error is tied to 0;
  - DRIVE goes straight to GAP.

## Test plan
- Reset then a single push of 8'hA5 with HOLD=1, no ACK:
  - BusSel=3'b111 and BusData=8'hA5 for exactly 1 cycle, starting 2 cycles after the push;
  - then 8'h00 and 3'b000;
  - Busy returns to 0.
- Push 5 bytes (8'h01 to 8'h05) back-to-back with DEPTH=4 and the bus stalled by HOLD=3:
  - InReady=0 when Count=4;
  - the fifth byte is accepted once the first pop occurs;
  - the bus shows 01, 02, 03, 04, 05 in order, each followed by one 3'b000 cycle.
- Continuous push and pop with the FIFO at Count=2: Count stays 2 and the pointers wrap past DEPTH-1 with correct data order.
- ACK build, BusAck asserted on the 3rd WAIT_ACK cycle: the byte stays qualified until that edge, then one GAP cycle; Error stays 0.
- ACK build, BusAck never asserted, ACK_TIMEOUT=4: Error pulses for 1 cycle after 4 WAIT_ACK cycles, the byte is dropped, and the next byte proceeds.
- Reset_n pulled low mid-DRIVE, between clock edges:
  - BusSel=3'b000 and BusData=8'h00 immediately;
  - Count=0 and InReady=1;
  - normal operation resumes after release.
